// File: rtl/axil_result_sink.sv
// AXI4-Lite slave that captures every word written to DATA into a small FIFO.
// Software drains it through DATA reads and reads STATUS/LAST through the same slave.
module axil_result_sink #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH         = 4,
   localparam int PTR_W  = $clog2(FIFO_DEPTH),
   localparam int LVL_W  = PTR_W + 1,
   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [STRB_W-1:0]             S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [LVL_W-1:0]              FIFO_LEVEL,
   output logic                          IRQ
);

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_LAST   = 2'd3;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state;
   r_state_t r_state;

   logic                          aw_rdy, ar_rdy, bvalid, rvalid;
   logic [1:0]                    bresp, rresp;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

   logic [C_S_AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]              wptr, rptr;
   logic [LVL_W-1:0]              level, level_nxt;
   logic                          ovf, irq;
   logic [C_S_AXI_DATA_WIDTH-1:0] last;

   logic [1:0]                    wr_sel, rd_sel;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_m, status, rd_word;
   logic                          wr_hs, rd_hs, full, empty;
   logic                          push_req, push_ok, pop_req, pop_ok, flush, clr_ovf;
   logic [1:0]                    rd_resp;
   logic                          unused_ok;

   function automatic logic [C_S_AXI_DATA_WIDTH-1:0] apply_strb(
      input logic [C_S_AXI_DATA_WIDTH-1:0] d,
      input logic [STRB_W-1:0]             s);
      logic [C_S_AXI_DATA_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < STRB_W; i++)
         if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   assign wr_sel  = S_AXI_AWADDR[3:2];
   assign rd_sel  = S_AXI_ARADDR[3:2];
   assign wdata_m = apply_strb(S_AXI_WDATA, S_AXI_WSTRB);

   // Both readies pulse in the cycle after the valids are seen; the master holds valids through it.
   assign wr_hs = (w_state == W_IDLE) && aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
   assign rd_hs = (r_state == R_IDLE) && ar_rdy && S_AXI_ARVALID;

   assign full     = (level == LVL_W'(FIFO_DEPTH));
   assign empty    = (level == '0);
   assign push_req = wr_hs && (wr_sel == ADDR_DATA);
   assign push_ok  = push_req && !full;
   assign pop_req  = rd_hs && (rd_sel == ADDR_DATA);
   assign pop_ok   = pop_req && !empty;
   assign flush    = wr_hs && (wr_sel == ADDR_CTRL) && wdata_m[0];
   assign clr_ovf  = wr_hs && (wr_sel == ADDR_CTRL) && wdata_m[1];

   always_comb begin
      level_nxt = level;
      if (flush)
         level_nxt = '0;
      else if (push_ok && !pop_ok)
         level_nxt = level + LVL_W'(1);
      else if (pop_ok && !push_ok)
         level_nxt = level - LVL_W'(1);
   end

   always_comb begin
      status              = '0;
      status[0]           = empty;
      status[1]           = full;
      status[2]           = ovf;
      status[8 +: LVL_W]  = level;
   end

   always_comb begin
      rd_word = '0;
      rd_resp = RESP_OKAY;
      case (rd_sel)
         ADDR_DATA: begin
            if (empty) rd_resp = RESP_SLVERR;
            else       rd_word = mem[rptr];
         end
         ADDR_STATUS: rd_word = status;
         ADDR_LAST:   rd_word = last;
         default:     rd_word = '0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state <= W_IDLE;
         aw_rdy  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_rdy) begin
                  aw_rdy <= 1'b0;
                  if (S_AXI_AWVALID && S_AXI_WVALID) begin
                     bvalid  <= 1'b1;
                     bresp   <= (push_req && full) ? RESP_SLVERR : RESP_OKAY;
                     w_state <= W_RESP;
                  end
               end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                  aw_rdy <= 1'b1;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  bvalid  <= 1'b0;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state <= R_IDLE;
         ar_rdy  <= 1'b0;
         rvalid  <= 1'b0;
         rresp   <= RESP_OKAY;
         rdata   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_rdy) begin
                  ar_rdy <= 1'b0;
                  if (S_AXI_ARVALID) begin
                     rvalid  <= 1'b1;
                     rdata   <= rd_word;
                     rresp   <= rd_resp;
                     r_state <= R_DATA;
                  end
               end else if (S_AXI_ARVALID) begin
                  ar_rdy <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  rvalid  <= 1'b0;
                  r_state <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Flush moves the read pointer onto the write pointer; a concurrent pop already captured the old head.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         irq   <= 1'b0;
         ovf   <= 1'b0;
         last  <= '0;
      end else begin
         level <= level_nxt;
         irq   <= (level_nxt != '0);
         if (push_ok) begin
            wptr <= wptr + PTR_W'(1);
            last <= wdata_m;
         end
         if (flush)       rptr <= wptr;
         else if (pop_ok) rptr <= rptr + PTR_W'(1);
         if (push_req && full) ovf <= 1'b1;
         else if (clr_ovf)     ovf <= 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (push_ok) mem[wptr] <= wdata_m;
   end

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = aw_rdy;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = bresp;
   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RDATA   = rdata;
   assign S_AXI_RRESP   = rresp;
   assign FIFO_LEVEL    = level;
   assign IRQ           = irq;

endmodule

// File: tb/tb_axil_result_sink.sv
// Bench for axil_result_sink: directed scenarios plus a randomized run against a queue-based model.
module tb_axil_result_sink;

   localparam int DEPTH = 4;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [2:0]  fifo_level;

   int checks   = 0;
   int failures = 0;

   // Reference model
   logic [31:0] mq[$];
   logic        m_ovf;
   logic [31:0] m_last;

   axil_result_sink #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
      .ACLK(aclk), .ARESETN(aresetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .FIFO_LEVEL(fifo_level), .IRQ(irq)
   );

   always #5 aclk = ~aclk;

   function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m = 0;
      for (int b = 0; b < 4; b++)
         if (s[b]) m = m | (d & (32'hFF << (8 * b)));
      return m;
   endfunction

   function automatic logic [31:0] model_status();
      int n = mq.size();
      return (n << 8) | (int'(m_ovf) << 2) | (int'(n == DEPTH) << 1) | int'(n == 0);
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_last = 32'h0;
   endfunction

   // Expected write response from the model, updating it as the write is applied
   function automatic logic [1:0] model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m = masked(d, s);
      if (a[3:2] == 2'd0) begin
         if (mq.size() == DEPTH) begin
            m_ovf = 1'b1;
            return 2'b10;
         end
         mq.push_back(m);
         m_last = m;
      end else if (a[3:2] == 2'd2) begin
         if (m[0]) mq.delete();
         if (m[1]) m_ovf = 1'b0;
      end
      return 2'b00;
   endfunction

   function automatic void model_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
      r = 2'b00;
      d = 32'h0;
      case (a[3:2])
         2'd0: if (mq.size() == 0) r = 2'b10; else d = mq.pop_front();
         2'd1: d = model_status();
         2'd3: d = m_last;
         default: d = 32'h0;
      endcase
   endfunction

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n = 0;
      @(negedge aclk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      while (!awready && n < 50) begin @(negedge aclk); n++; end
      if (!awready) begin
         checks++; failures++;
         $display("FAIL write_timeout awready=%0b required=1", awready);
      end
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin @(negedge aclk); n++; end
      if (!bvalid) begin
         checks++; failures++;
         $display("FAIL bvalid_timeout bvalid=%0b required=1", bvalid);
      end
      resp = bresp;
      @(posedge aclk); #1;
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      @(negedge aclk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (!arready && n < 50) begin @(negedge aclk); n++; end
      if (!arready) begin
         checks++; failures++;
         $display("FAIL read_timeout arready=%0b required=1", arready);
      end
      @(posedge aclk); #1;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge aclk); n++; end
      if (!rvalid) begin
         checks++; failures++;
         $display("FAIL rvalid_timeout rvalid=%0b required=1", rvalid);
      end
      d = rdata; resp = rresp;
      @(posedge aclk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      aresetn = 1'b0;
      awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      model_reset();
      repeat (3) @(negedge aclk);
      checks++;
      if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, fifo_level, irq} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got aw=%0b w=%0b b=%0b bresp=%0d ar=%0b r=%0b rdata=%h rresp=%0d lvl=%0d irq=%0b required all 0",
                  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, fifo_level, irq);
      end
      aresetn = 1'b1;
      axi_read(4'h4, d, r);
      checks++;
      if (d !== 32'h1 || r !== 2'b00) begin
         failures++;
         $display("FAIL reset_status got %h/%0d required 00000001/0", d, r);
      end
   endtask

   task automatic test_fill_drain();
      logic [31:0] d, ed;
      logic [1:0]  r, er;
      for (int i = 1; i <= 5; i++) begin
         er = model_write(4'h0, 32'h11 * i, 4'hF);
         axi_write(4'h0, 32'h11 * i, 4'hF, r);
         checks++;
         if (r !== er) begin
            failures++;
            $display("FAIL fill_bresp[%0d] got %0d required %0d", i, r, er);
         end
         if (i == 4) begin
            axi_read(4'h4, d, r);
            checks++;
            if (d !== 32'h402 || d !== model_status()) begin
               failures++;
               $display("FAIL full_status got %h required 00000402", d);
            end
            checks++;
            if (irq !== 1'b1 || fifo_level !== 3'd4) begin
               failures++;
               $display("FAIL full_level got irq=%0b lvl=%0d required irq=1 lvl=4", irq, fifo_level);
            end
            axi_read(4'hC, d, r);
            checks++;
            if (d !== 32'h44) begin
               failures++;
               $display("FAIL last_word got %h required 00000044", d);
            end
         end
      end
      axi_read(4'h4, d, r);
      checks++;
      if (d !== 32'h406) begin
         failures++;
         $display("FAIL overflow_status got %h required 00000406", d);
      end
      for (int i = 1; i <= 5; i++) begin
         model_read(4'h0, ed, er);
         axi_read(4'h0, d, r);
         checks++;
         if (d !== ed || r !== er) begin
            failures++;
            $display("FAIL drain[%0d] got %h/%0d required %h/%0d", i, d, r, ed, er);
         end
      end
      axi_read(4'h4, d, r);
      checks++;
      if (d !== 32'h5 || irq !== 1'b0) begin
         failures++;
         $display("FAIL drained_status got %h irq=%0b required 00000005 irq=0", d, irq);
      end
   endtask

   task automatic test_ctrl_strobe();
      logic [31:0] d;
      logic [1:0]  r;
      void'(model_write(4'h8, 32'h2, 4'hF));
      axi_write(4'h8, 32'h2, 4'hF, r);
      axi_read(4'h4, d, r);
      checks++;
      if (d !== 32'h1) begin
         failures++;
         $display("FAIL clear_ovf_status got %h required 00000001", d);
      end
      void'(model_write(4'h0, 32'hAABBCCDD, 4'b0011));
      axi_write(4'h0, 32'hAABBCCDD, 4'b0011, r);
      axi_read(4'h0, d, r);
      void'(mq.pop_front());
      checks++;
      if (d !== 32'h0000CCDD || r !== 2'b00) begin
         failures++;
         $display("FAIL strobe_data got %h/%0d required 0000ccdd/0", d, r);
      end
   endtask

   task automatic test_stall();
      logic [31:0] d, ed;
      logic [1:0]  r, er;
      int n = 0;
      // Write response held off while a second write is pending
      void'(model_write(4'h0, 32'hA1, 4'hF));
      @(negedge aclk);
      awaddr = 4'h0; wdata = 32'hA1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      while (!awready && n < 50) begin @(negedge aclk); n++; end
      @(posedge aclk); #1;
      wdata = 32'hA2;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         checks++;
         if (bvalid !== 1'b1 || awready !== 1'b0) begin
            failures++;
            $display("FAIL bready_stall[%0d] got bvalid=%0b awready=%0b required 1/0", i, bvalid, awready);
         end
      end
      bready = 1'b1;
      @(posedge aclk); #1;
      n = 0;
      while (!awready && n < 50) begin @(negedge aclk); n++; end
      checks++;
      if (!awready) begin
         failures++;
         $display("FAIL second_write_timeout awready=%0b required=1", awready);
      end
      @(posedge aclk); #1;
      awvalid = 0; wvalid = 0;
      er = model_write(4'h0, 32'hA2, 4'hF);
      checks++;
      if (bvalid !== 1'b1 || bresp !== er) begin
         failures++;
         $display("FAIL second_write_resp got bvalid=%0b bresp=%0d required 1/%0d", bvalid, bresp, er);
      end
      @(posedge aclk); #1;
      // Read data held off while a second read is pending
      model_read(4'h0, ed, er);
      n = 0;
      @(negedge aclk);
      araddr = 4'h0; arvalid = 1; rready = 0;
      while (!arready && n < 50) begin @(negedge aclk); n++; end
      @(posedge aclk); #1;
      araddr = 4'h4;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         checks++;
         if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== ed) begin
            failures++;
            $display("FAIL rready_stall[%0d] got rvalid=%0b arready=%0b rdata=%h required 1/0/%h",
                     i, rvalid, arready, rdata, ed);
         end
      end
      rready = 1'b1;
      @(posedge aclk); #1;
      n = 0;
      while (!arready && n < 50) begin @(negedge aclk); n++; end
      @(posedge aclk); #1;
      arvalid = 0;
      model_read(4'h4, ed, er);
      checks++;
      if (rvalid !== 1'b1 || rdata !== ed) begin
         failures++;
         $display("FAIL second_read got rvalid=%0b rdata=%h required 1/%h", rvalid, rdata, ed);
      end
      @(posedge aclk); #1;
      while (mq.size() > 0) begin
         model_read(4'h0, ed, er);
         axi_read(4'h0, d, r);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, ed, x;
      logic [1:0]  r, er;
      logic [3:0]  a, s;
      int op;
      for (int i = 0; i < 200; i++) begin
         op = $urandom_range(0, 9);
         x  = $urandom;
         s  = 4'($urandom_range(0, 15));
         if (op <= 3) begin
            er = model_write(4'h0, x, s);
            axi_write(4'h0, x, s, r);
            d = 32'h0; ed = 32'h0;
         end else if (op == 9) begin
            a = ($urandom_range(0, 1) == 0) ? 4'h4 : 4'hC;
            if ($urandom_range(0, 3) == 0) begin
               a = 4'h8;
               x = {30'h0, ($urandom_range(0, 2) == 0), 1'b0} | (($urandom_range(0, 4) == 0) ? 32'h1 : 32'h0);
               s = 4'hF;
            end
            er = model_write(a, x, s);
            axi_write(a, x, s, r);
            d = 32'h0; ed = 32'h0;
         end else begin
            a = (op <= 6) ? 4'h0 : {op == 7 ? 2'd1 : 2'd3, 2'b00};
            if (op == 8 && $urandom_range(0, 2) == 0) a = 4'h8;
            model_read(a, ed, er);
            axi_read(a, d, r);
         end
         checks++;
         if (r !== er || d !== ed || fifo_level !== 3'(mq.size()) || irq !== (mq.size() != 0)) begin
            failures++;
            $display("FAIL random[%0d] op=%0d got %h/%0d lvl=%0d irq=%0b required %h/%0d lvl=%0d",
                     i, op, d, r, fifo_level, irq, ed, er, mq.size());
         end
      end
   endtask

   task automatic test_flush_pop_reset();
      logic [31:0] d, ed;
      logic [1:0]  r;
      int n = 0;
      void'(model_write(4'h8, 32'h3, 4'hF));
      axi_write(4'h8, 32'h3, 4'hF, r);
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         void'(model_write(4'h0, d, 4'hF));
         axi_write(4'h0, d, 4'hF, r);
      end
      ed = mq[0];
      mq.delete();
      @(negedge aclk);
      araddr = 4'h0; arvalid = 1; rready = 0;
      awaddr = 4'h8; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
      while (!(awready && arready) && n < 20) begin @(negedge aclk); n++; end
      checks++;
      if (!(awready && arready)) begin
         failures++;
         $display("FAIL concurrent_handshake got awready=%0b arready=%0b required 1/1", awready, arready);
      end
      @(posedge aclk); #1;
      arvalid = 0; awvalid = 0; wvalid = 0;
      @(posedge aclk); #1;
      checks++;
      if (rvalid !== 1'b1 || rdata !== ed || rresp !== 2'b00 || fifo_level !== 3'd0) begin
         failures++;
         $display("FAIL flush_pop got rvalid=%0b rdata=%h rresp=%0d lvl=%0d required 1/%h/0/0",
                  rvalid, rdata, rresp, fifo_level, ed);
      end
      @(negedge aclk);
      aresetn = 1'b0;
      #1;
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'h0 || fifo_level !== 3'd0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got rvalid=%0b rdata=%h lvl=%0d irq=%0b required 0", rvalid, rdata, fifo_level, irq);
      end
      model_reset();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      rready = 1'b1;
      axi_read(4'h4, d, r);
      checks++;
      if (d !== 32'h1 || r !== 2'b00) begin
         failures++;
         $display("FAIL post_reset_status got %h/%0d required 00000001/0", d, r);
      end
      axi_read(4'hC, d, r);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL post_reset_last got %h required 00000000", d);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_ctrl_strobe();
      test_stall();
      test_random();
      test_flush_pop_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
